// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding and default constants for the sample converter and its generator
package conv_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK = 2'd1;
  localparam logic [1:0] S_CONV = 2'd2;
  localparam int CONV_CYCLES_DEF = 4;
  localparam int MIN_VAL_DEF = 6;
endpackage

// File: rtl/conv_timer.sv
// conv_timer: 8-bit loadable down-counter (clock, reset, load, load_val, en in; zero out)
module conv_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       zero
);
  logic [7:0] cnt;
  always_ff @(posedge clock)
    cnt <= reset ? 8'd0 : load ? load_val : en ? cnt - 8'd1 : cnt;
  assign zero = cnt == 8'd0;
endmodule

// File: rtl/conv_numero.sv
// conv_numero: soc/eoc sample converter with MIN_VAL clamp (clock, reset, soc, x in; eoc, numero, clamped out)
module conv_numero
  import conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CONV_CYCLES = CONV_CYCLES_DEF,
  parameter int MIN_VAL = MIN_VAL_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soc,
  input  logic [WIDTH-1:0] x,
  output logic             eoc,
  output logic [WIDTH-1:0] numero,
  output logic             clamped
);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  logic [1:0] state;
  logic [WIDTH-1:0] xs;
  logic zero;
  logic lo;
  assign lo = xs < MIN_W;
  conv_timer u_timer (
    .clock(clock),
    .reset(reset),
    .load(state == S_ACK && !soc),
    .load_val(8'(CONV_CYCLES - 1)),
    .en(state == S_CONV && !zero),
    .zero(zero)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_IDLE;
      eoc <= 1'b1;
      numero <= MIN_W;
      clamped <= 1'b0;
      xs <= '0;
    end else if (state == S_IDLE) begin
      if (soc) begin
        state <= S_ACK;
        eoc <= 1'b0;
      end
    end else if (state == S_ACK) begin
      if (!soc) begin
        xs <= x;
        state <= S_CONV;
      end
    end else if (zero) begin
      numero <= lo ? MIN_W : xs;
      clamped <= lo;
      eoc <= 1'b1;
      state <= S_IDLE;
    end
endmodule

// File: doc/conv_numero.md
# conv_numero

Upstream stage of the square-wave generator: an 8-bit sample converter that answers the generator's `soc`/`eoc` handshake and delivers the half-period value on `numero`. Each conversion samples the input `x`, clamps it to a floor of `MIN_VAL` so the generator never receives a degenerate half-period, and completes after a fixed latency. The converter sits directly between the sample source and the generator's `numero`/`eoc` inputs.

## Interface
- `WIDTH`, 8: data width of `x` and `numero`.
- `CONV_CYCLES`, 4: conversion latency in clock cycles; legal range 1..255.
- `MIN_VAL`, 6: clamp floor for results; must satisfy 1 ≤ `MIN_VAL` < 2^`WIDTH`.

- `clock`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: reset; synchronous, active-high.
- `soc`, input, 1: start of conversion, driven by the generator.
- `x`, input, WIDTH: raw sample, captured once per conversion.
- `eoc`, output, 1: end of conversion; 1 means idle with a valid result.
- `numero`, output, WIDTH: conversion result; stable whenever `eoc` = 1.
- `clamped`, output, 1: 1 when the current `numero` was raised to `MIN_VAL`.

## Operation
- All outputs are registered.
- The block has three states:
  - IDLE: `eoc` = 1. If `soc` = 1 is sampled, move to ACK.
  - ACK: `eoc` = 0. If `soc` = 0 is sampled, capture `x`, load the counter with `CONV_CYCLES`-1, and move to CONV.
  - CONV: `eoc` = 0. If the counter is 0, write the result to `numero`, update `clamped`, set `eoc` = 1, and move to IDLE. Otherwise decrement the counter.
- Result rule: `numero` = `MIN_VAL` if captured `x` < `MIN_VAL`, else captured `x`. `clamped` = (captured `x` < `MIN_VAL`). The comparison is unsigned at WIDTH bits.
- `numero` and `clamped` hold their previous values through ACK and CONV. They are never driven X.
- Changes of `x` outside the capture edge have no effect.
- Reset values: state IDLE, `eoc` = 1, `numero` = `MIN_VAL`, `clamped` = 0, counter = 0.

## Timing
- Edge k samples `soc` = 1 in IDLE: `eoc` falls after edge k (1-cycle acknowledge).
- Edge m samples `soc` = 0 in ACK: `x` is captured at edge m.
- `eoc` rises, and the new `numero` appears, after edge m + `CONV_CYCLES`. Both update on the same edge.
- With `CONV_CYCLES` = 1, the result appears at edge m+1.
- `soc` held at 1 in ACK: the block waits indefinitely with `eoc` = 0.
- `soc` toggling during CONV: ignored. The conversion completes on schedule.
- `soc` = 1 sampled on the same edge that returns to IDLE: not acted on. The next edge, in IDLE, starts a new handshake.
- `soc` = 1 still asserted after a return to IDLE: treated as a new request.
- `reset` in any state aborts the conversion immediately. All outputs take their reset values on that edge, and `reset` has priority over every transition.
- Back-to-back conversions: the minimum spacing is 1 (IDLE) + 1 (ACK) + `CONV_CYCLES` cycles.

## Structure
- Shared package `conv_pkg`:
  - State encoding localparams `S_IDLE`, `S_ACK`, `S_CONV` (2 bits).
  - Default constants `CONV_CYCLES_DEF` = 4 and `MIN_VAL_DEF` = 6. The generator's bench reuses the same floor.
- One sub-module, `conv_timer`: an 8-bit loadable down-counter.
  - Inputs: `load`, `load_val`, `en`.
  - Output: `zero`.
- The top level holds the FSM, the capture register, and the clamp comparator.

## Test plan
- Reset: hold `reset` = 1 for 2 cycles, then release -> `eoc` = 1, `numero` = 6, `clamped` = 0; no change while `soc` stays 0.
- Nominal handshake: `x` = 40, raise `soc` -> `eoc` = 0 after the next edge. Drop `soc` at edge m -> `eoc` = 1, `numero` = 40, `clamped` = 0 after edge m+4.
- Clamp: `x` = 3, then `x` = 0, then `x` = 6 -> `numero` = 6 with `clamped` = 1, 1, 0. Then `x` = 255 -> `numero` = 255, `clamped` = 0.
- Capture timing: change `x` from 50 to 90 one cycle after the `soc` fall edge -> result is 50. `numero` holds its old value while `eoc` = 0.
- Reset mid-conversion: assert `reset` 2 cycles into CONV -> `eoc` = 1, `numero` = 6 after that edge. A following full handshake with `x` = 20 -> 20.
- Closed loop with the generator: 32 consecutive conversions with `x` = {i, 2'b11, i[0]} for i = 0..31 -> each `eoc` rise occurs `CONV_CYCLES` edges after the `soc` fall. The generator's 0- and 1-phases each measure `numero` cycles. Repeat the run with `CONV_CYCLES` = 1 and 255.
